// File: rtl/wm_sequencer_if.sv
// wm_sequencer_if: operator/timer handshake and actuator bundle for the washing-machine sequencer.
// cold_wash exists only when WM_COLD_WASH_EN is defined.
interface wm_sequencer_if;
    logic       start;
    logic       door_closed;
    logic       fault_clear;
    logic       sig_Full;
    logic       sig_Temperature;
    logic       sig_Wash_Completed;
    logic       sig_Rinse_Completed;
    logic       sig_Spin_Completed;
`ifdef WM_COLD_WASH_EN
    logic       cold_wash;
`endif
    logic [2:0] state;
    logic       water_valve;
    logic       heater;
    logic       motor_wash;
    logic       motor_spin;
    logic       door_lock;
    logic       done;
    logic       fault;

    modport slave (
`ifdef WM_COLD_WASH_EN
        input  cold_wash,
`endif
        input  start, door_closed, fault_clear,
        input  sig_Full, sig_Temperature, sig_Wash_Completed,
        input  sig_Rinse_Completed, sig_Spin_Completed,
        output state, water_valve, heater, motor_wash, motor_spin,
        output door_lock, done, fault
    );

    modport master (
`ifdef WM_COLD_WASH_EN
        output cold_wash,
`endif
        output start, door_closed, fault_clear,
        output sig_Full, sig_Temperature, sig_Wash_Completed,
        output sig_Rinse_Completed, sig_Spin_Completed,
        input  state, water_valve, heater, motor_wash, motor_spin,
        input  door_lock, done, fault
    );
endinterface

// File: rtl/wm_sequencer.sv
// wm_sequencer: washing-machine master FSM with door guard and per-phase watchdog.
// Optional macro WM_COLD_WASH_EN adds a cold-wash mode that skips HEAT_WATER.
module wm_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic          clock,
    input  logic          reset,
    wm_sequencer_if.slave bus
);
    localparam int unsigned   CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_W = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] WDOG_ONE  = CW'(1);

    localparam logic [2:0] STATE_START      = 3'd0;
    localparam logic [2:0] STATE_READY      = 3'd1;
    localparam logic [2:0] STATE_FILL_WATER = 3'd2;
    localparam logic [2:0] STATE_HEAT_WATER = 3'd3;
    localparam logic [2:0] STATE_WASH       = 3'd4;
    localparam logic [2:0] STATE_RINSE      = 3'd5;
    localparam logic [2:0] STATE_SPIN       = 3'd6;
    localparam logic [2:0] STATE_FAULT      = 3'd7;

    logic [2:0]    state_q, state_d, succ_s;
    logic [CW-1:0] wdog_q, wdog_d;
    logic          start_prev_q;
    logic          start_edge_s, flag_s, active_s, cold_s;
    logic          done_q, done_d;
    logic          water_valve_q, water_valve_d;
    logic          heater_q, heater_d;
    logic          motor_wash_q, motor_wash_d;
    logic          motor_spin_q, motor_spin_d;
    logic          door_lock_q, door_lock_d;
    logic          fault_q, fault_d;

    assign start_edge_s = bus.start & ~start_prev_q;
    assign active_s     = (state_q >= STATE_FILL_WATER) && (state_q <= STATE_SPIN);

`ifdef WM_COLD_WASH_EN
    logic mode_q, mode_d;

    assign cold_s = mode_q;

    // Cold-wash mode is latched on the READY->FILL_WATER step and dropped in START.
    always_comb begin
        mode_d = mode_q;
        if (state_q == STATE_START) begin
            mode_d = 1'b0;
        end else if ((state_q == STATE_READY) && (state_d == STATE_FILL_WATER)) begin
            mode_d = bus.cold_wash;
        end else begin
            mode_d = mode_q;
        end
    end

    // Mode bit register.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end
`else
    assign cold_s = 1'b0;
`endif

    // Completion flag owned by the current phase and the phase it leads to.
    always_comb begin
        succ_s = state_q;
        flag_s = 1'b0;
        case (state_q)
            STATE_FILL_WATER: begin
                flag_s = bus.sig_Full;
                succ_s = cold_s ? STATE_WASH : STATE_HEAT_WATER;
            end
            STATE_HEAT_WATER: begin
                flag_s = bus.sig_Temperature;
                succ_s = STATE_WASH;
            end
            STATE_WASH: begin
                flag_s = bus.sig_Wash_Completed;
                succ_s = STATE_RINSE;
            end
            STATE_RINSE: begin
                flag_s = bus.sig_Rinse_Completed;
                succ_s = STATE_SPIN;
            end
            STATE_SPIN: begin
                flag_s = bus.sig_Spin_Completed;
                succ_s = STATE_START;
            end
            default: begin
                flag_s = 1'b0;
                succ_s = state_q;
            end
        endcase
    end

    // Next phase (door > completion > timeout), watchdog and done pulse.
    always_comb begin
        state_d = state_q;
        wdog_d  = {CW{1'b0}};
        case (state_q)
            STATE_START: state_d = STATE_READY;
            STATE_READY: begin
                if (start_edge_s && bus.door_closed) begin
                    state_d = STATE_FILL_WATER;
                end else begin
                    state_d = STATE_READY;
                end
            end
            STATE_FILL_WATER, STATE_HEAT_WATER, STATE_WASH, STATE_RINSE, STATE_SPIN: begin
                if (!bus.door_closed) begin
                    state_d = STATE_FAULT;
                end else if (flag_s) begin
                    state_d = succ_s;
                end else if (wdog_q == TIMEOUT_W) begin
                    state_d = STATE_FAULT;
                end else begin
                    state_d = state_q;
                end
            end
            STATE_FAULT: begin
                if (bus.fault_clear && bus.door_closed) begin
                    state_d = STATE_START;
                end else begin
                    state_d = STATE_FAULT;
                end
            end
            default: state_d = STATE_START;
        endcase
        if (active_s && (state_d == state_q)) begin
            wdog_d = wdog_q + WDOG_ONE;
        end else begin
            wdog_d = {CW{1'b0}};
        end
        done_d = (state_q == STATE_SPIN) && (state_d == STATE_START);
    end

    // Actuator decode from the next phase so the registered copies track state_q.
    always_comb begin
        water_valve_d = (state_d == STATE_FILL_WATER);
        heater_d      = (state_d == STATE_HEAT_WATER);
        motor_wash_d  = (state_d == STATE_WASH) || (state_d == STATE_RINSE);
        motor_spin_d  = (state_d == STATE_SPIN);
        door_lock_d   = (state_d >= STATE_FILL_WATER) && (state_d <= STATE_SPIN);
        fault_d       = (state_d == STATE_FAULT);
    end

    // State, watchdog, start history and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= STATE_START;
            wdog_q        <= {CW{1'b0}};
            start_prev_q  <= 1'b0;
            done_q        <= 1'b0;
            water_valve_q <= 1'b0;
            heater_q      <= 1'b0;
            motor_wash_q  <= 1'b0;
            motor_spin_q  <= 1'b0;
            door_lock_q   <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wdog_q        <= wdog_d;
            start_prev_q  <= bus.start;
            done_q        <= done_d;
            water_valve_q <= water_valve_d;
            heater_q      <= heater_d;
            motor_wash_q  <= motor_wash_d;
            motor_spin_q  <= motor_spin_d;
            door_lock_q   <= door_lock_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.water_valve = water_valve_q;
    assign bus.heater      = heater_q;
    assign bus.motor_wash  = motor_wash_q;
    assign bus.motor_spin  = motor_spin_q;
    assign bus.door_lock   = door_lock_q;
    assign bus.done        = done_q;
    assign bus.fault       = fault_q;
endmodule
